// File: rtl/multiplier_limb_seq.sv
// -----------------------------------------------------------------------------
// multiplier_limb_seq
//
// Sequential MUL_SIZE x MUL_SIZE multiplier built from a single LIMB x LIMB
// multiplier. Operands are split into N = MUL_SIZE/LIMB limbs. One partial
// product is accumulated per cycle (j inner, i outer) into a full-width
// 2*MUL_SIZE accumulator, so the final value is the exact product. res shows
// the slice [OUT_LO+OUT_W-1:OUT_LO] of the accumulator.
//
// Optional feature: define MUL_DSP_PREG_EN to insert a pipeline register
// between the limb multiplier and the accumulator (one extra cycle of latency,
// identical results).
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b present
//   in_ready   block accepts operands (IDLE only)
//   a, b       MUL_SIZE-bit multiplicand / multiplier
//   out_valid  res holds a finished result (DONE only)
//   out_ready  consumer takes the result
//   res        OUT_W-bit product slice starting at bit OUT_LO
// -----------------------------------------------------------------------------
module multiplier_limb_seq #(
    parameter int MUL_SIZE = 66,
    parameter int LIMB     = 22,
    parameter int OUT_LO   = 64,
    parameter int OUT_W    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MUL_SIZE-1:0] a,
    input  logic [MUL_SIZE-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    res
);

    localparam int N  = MUL_SIZE / LIMB;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * MUL_SIZE;
    localparam int LW = 2 * LIMB;

    // Elaboration-time parameter sanity checks
    if (MUL_SIZE % LIMB != 0) begin : gen_bad_limb
        $error("MUL_SIZE must be an integer multiple of LIMB");
    end
    if (OUT_LO + OUT_W > 2 * MUL_SIZE) begin : gen_bad_slice
        $error("OUT_LO + OUT_W must not exceed 2*MUL_SIZE");
    end

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [MUL_SIZE-1:0] a_q;
    logic [MUL_SIZE-1:0] b_q;
    logic [PW-1:0]       acc_q;
    logic [IW-1:0]       i_q;
    logic [IW-1:0]       j_q;

    logic [LIMB-1:0]     a_limb;
    logic [LIMB-1:0]     b_limb;
    logic [LW-1:0]       prod;
    logic [IW:0]         cur_sh;
    logic                last_term;

    logic [LW-1:0]       add_prod;
    logic [IW:0]         add_sh;
    logic [PW-1:0]       addend;

`ifdef MUL_DSP_PREG_EN
    logic [LW-1:0]       pp_q;
    logic [IW:0]         sh_q;
    logic                pp_vld_q;
    logic                issue_done_q;
`endif

    // Limb multiplier on the currently indexed limbs
    always_comb begin
        a_limb    = a_q[i_q*LIMB +: LIMB];
        b_limb    = b_q[j_q*LIMB +: LIMB];
        prod      = LW'(a_limb) * LW'(b_limb);
        cur_sh    = {1'b0, i_q} + {1'b0, j_q};
        last_term = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));
    end

    // Source of the term added to the accumulator: direct or registered
    always_comb begin
`ifdef MUL_DSP_PREG_EN
        add_prod = pp_q;
        add_sh   = sh_q;
`else
        add_prod = prod;
        add_sh   = cur_sh;
`endif
        addend = PW'(add_prod) << (LIMB * int'(add_sh));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            i_q          <= '0;
            j_q          <= '0;
`ifdef MUL_DSP_PREG_EN
            pp_q         <= '0;
            sh_q         <= '0;
            pp_vld_q     <= 1'b0;
            issue_done_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q          <= a;
                        b_q          <= b;
                        acc_q        <= '0;
                        i_q          <= '0;
                        j_q          <= '0;
`ifdef MUL_DSP_PREG_EN
                        pp_vld_q     <= 1'b0;
                        issue_done_q <= 1'b0;
`endif
                        in_ready_q   <= 1'b0;
                        state_q      <= StMul;
                    end
                end

                StMul: begin
`ifdef MUL_DSP_PREG_EN
                    // Issue stage: register one partial product per cycle
                    if (!issue_done_q) begin
                        pp_q     <= prod;
                        sh_q     <= cur_sh;
                        pp_vld_q <= 1'b1;
                        if (last_term) begin
                            issue_done_q <= 1'b1;
                            i_q          <= '0;
                            j_q          <= '0;
                        end else if (j_q == IW'(N - 1)) begin
                            j_q <= '0;
                            i_q <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        pp_vld_q <= 1'b0;
                    end
                    // Accumulate stage; once issuing is done the pending term is the last
                    if (pp_vld_q) begin
                        acc_q <= acc_q + addend;
                        if (issue_done_q) begin
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
`else
                    acc_q <= acc_q + addend;
                    if (last_term) begin
                        i_q         <= '0;
                        j_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else if (j_q == IW'(N - 1)) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
`endif
                end

                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = acc_q[OUT_LO +: OUT_W];

endmodule

// File: doc/multiplier_limb_seq.md
MULTIPLIER_LIMB_SEQ -- requirements
Module: multiplier_limb_seq

Interface
REQ-001 SHALL have parameter MUL_SIZE, default 66: operand width in bits.
REQ-002 SHALL have parameter LIMB, default 22: DSP limb width; MUL_SIZE is an integer multiple of LIMB.
REQ-003 SHALL have parameter OUT_LO, default 64: LSB index of the product slice driven on res.
REQ-004 SHALL have parameter OUT_W, default 64: width of res; OUT_LO+OUT_W <= 2*MUL_SIZE.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: operands a/b present.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-009 SHALL have port a, input, MUL_SIZE bits: multiplicand.
REQ-010 SHALL have port b, input, MUL_SIZE bits: multiplier.
REQ-011 SHALL have port out_valid, output, 1 bit: res holds a finished result.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-013 SHALL have port res, output, OUT_W bits: product bits [OUT_LO+OUT_W-1:OUT_LO].

Function
REQ-014 SHALL implement an FSM with states IDLE, MUL, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 SHALL accept on in_valid&&in_ready: latch a and b, clear the 2*MUL_SIZE-bit accumulator, zero limb indices i,j, go to MUL.
REQ-016 SHALL, with N=MUL_SIZE/LIMB, compute one LIMB x LIMB partial product per MUL cycle, a_limb[i]*b_limb[j] shifted left by LIMB*(i+j), added to the accumulator; j inner, i outer.
REQ-017 SHALL go MUL->DONE on the edge that adds the (i=N-1, j=N-1) term: out_valid rises N*N cycles after the accepting edge (9 at defaults).
REQ-018 SHALL perform the accumulator add at full 2*MUL_SIZE width without truncation; the final value equals the exact product a*b.
REQ-019 SHALL drive res from the accumulator slice and hold res and out_valid stable in DONE while out_ready=0.
REQ-020 SHALL go DONE->IDLE on out_valid&&out_ready; throughput is one result per N*N+2 cycles with out_ready held at 1.
REQ-021 SHALL ignore in_valid, a and b outside IDLE; operand changes after acceptance do not affect the result.
REQ-022 SHALL fail elaboration when MUL_SIZE%LIMB!=0 or OUT_LO+OUT_W>2*MUL_SIZE.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-MUL, go to IDLE immediately: in_ready=1, out_valid=0, res=0, accumulator/indices/operand registers=0; the in-flight operation is discarded.
REQ-024 SHALL accept new operands on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL support macro MUL_DSP_PREG_EN; when defined, a register is inserted between the limb multiplier and the accumulator, adding exactly one cycle (out_valid N*N+1 cycles after accept, 10 at defaults); when undefined, there is no register and latency is N*N; results are identical in both builds.

Verification
REQ-026 SHALL cover a=b=2^66-1 (defaults) -> res=0xFFFF_FFFF_FFFF_FFF8, out_valid 9 cycles after accept.
REQ-027 SHALL cover a=2^32, b=2^32 -> res=0x0000_0000_0000_0001; a=0 or b=0 -> res=0.
REQ-028 SHALL cover out_ready=0 for 5 cycles in DONE -> res and out_valid constant, in_ready=0; 1 cycle after out_ready=1, in_ready=1.
REQ-029 SHALL cover in_valid=1 with changing a/b during MUL -> no second accept; result equals the first operands' product.
REQ-030 SHALL cover rst_n pulsed low in MUL cycle 4 -> out_valid=0, res=0, in_ready=1 at once; the next operation (a=3, b=5, OUT_LO=0 build) yields res=15.
REQ-031 SHALL cover the MUL_DSP_PREG_EN build -> REQ-026 stimulus gives the same res with out_valid 10 cycles after accept.
